clk_gen_multi: RTL and testbench

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

---
 rtl/clk_gen_pkg.sv | 14 +
 rtl/clk_gen_chan.sv | 111 +++++++++++
 rtl/clk_gen_multi.sv | 36 +++
 tb/tb_clk_gen_multi.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the multi-channel clock generator.
// Optional phase delay is compiled in with CLK_GEN_PHASE_EN.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PHASE_WAIT = 2'd1,
        RUN        = 2'd2
    } chan_state_e;

    // Shortest period a channel will produce; smaller requests are raised to this.
    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/clk_gen_chan.sv
// One divided-clock channel: shadowed period/high/phase, IDLE/PHASE_WAIT/RUN FSM.
// Outputs are registered from the current state, one cycle behind it. Phase delay needs CLK_GEN_PHASE_EN.
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] phase_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             busy_o
);

    chan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_s_q;
    logic [CNT_W-1:0] high_s_q;
    logic             clk_out_q;
    logic             tick_q;
    logic             busy_q;

    logic [CNT_W-1:0] period_d;
    logic             last_d;

    // Requested periods below the minimum are clamped at sampling time.
    assign period_d = (period_i < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_i;
    assign last_d   = (cnt_q == (period_s_q - CNT_W'(1)));

`ifdef CLK_GEN_PHASE_EN
    logic [CNT_W-1:0] phase_s_q;
`else
    logic unused_phase;
    assign unused_phase = ^phase_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_s_q <= '0;
            high_s_q   <= '0;
`ifdef CLK_GEN_PHASE_EN
            phase_s_q  <= '0;
`endif
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            clk_out_q <= (state_q == RUN) && (cnt_q < high_s_q);
            tick_q    <= (state_q == RUN) && (cnt_q == '0);
            busy_q    <= (state_q != IDLE);

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (en_i) begin
                        period_s_q <= period_d;
                        high_s_q   <= high_i;
`ifdef CLK_GEN_PHASE_EN
                        phase_s_q  <= phase_i;
                        state_q    <= (phase_i != '0) ? PHASE_WAIT : RUN;
`else
                        state_q    <= RUN;
`endif
                    end
                end
`ifdef CLK_GEN_PHASE_EN
                PHASE_WAIT: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == (phase_s_q - CNT_W'(1))) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                RUN: begin
                    // Config is only re-sampled at the period boundary, so no runt pulses.
                    if (last_d) begin
                        cnt_q <= '0;
                        if (en_i) begin
                            period_s_q <= period_d;
                            high_s_q   <= high_i;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/clk_gen_multi.sv
// NUM_CH independent divided-clock channels sharing one system clock.
// Phase delay support is compiled in with CLK_GEN_PHASE_EN.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] period,
    input  logic [NUM_CH*CNT_W-1:0] high,
    input  logic [NUM_CH*CNT_W-1:0] phase,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_gen_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk_i    (clk),
            .rst_n_i  (rst_n),
            .en_i     (en[i]),
            .period_i (period[i*CNT_W +: CNT_W]),
            .high_i   (high[i*CNT_W +: CNT_W]),
            .phase_i  (phase[i*CNT_W +: CNT_W]),
            .clk_out_o(clk_out[i]),
            .tick_o   (tick[i]),
            .busy_o   (busy[i])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi: vector table plus hand sequences, scoreboard queue.
// Expectations follow CLK_GEN_PHASE_EN when the bench is built with it.
module tb_clk_gen_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 16;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] period;
    logic [NUM_CH*CNT_W-1:0] high;
    logic [NUM_CH*CNT_W-1:0] phase;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       busy;

    clk_gen_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .period (period),
        .high   (high),
        .phase  (phase),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        int                k;
        logic [NUM_CH-1:0] clk_e;
        logic [NUM_CH-1:0] tick_e;
        logic [NUM_CH-1:0] busy_e;
    } exp_t;

    // Bit strings: MSB is sample k=0 (the cycle right after the edge that samples en).
    typedef struct {
        string       name;
        int unsigned per;
        int unsigned hi;
        int unsigned ph;
        logic [11:0] clk_e;
        logic [11:0] tick_e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic set_cfg(input int ch, input int unsigned p, input int unsigned h, input int unsigned ph);
        period[ch*CNT_W +: CNT_W] = CNT_W'(p);
        high[ch*CNT_W +: CNT_W]   = CNT_W'(h);
        phase[ch*CNT_W +: CNT_W]  = CNT_W'(ph);
    endtask

    task automatic push_seq(input string name, input int n, input logic [15:0] cp,
                            input logic [15:0] tp, input logic [15:0] bp, input logic [NUM_CH-1:0] mask);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.name   = name;
            e.k      = k;
            e.clk_e  = cp[n-1-k] ? mask : '0;
            e.tick_e = tp[n-1-k] ? mask : '0;
            e.busy_e = bp[n-1-k] ? mask : '0;
            sb.push_back(e);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry for this cycle");
        end else begin
            e = sb.pop_front();
            if (clk_out !== e.clk_e || tick !== e.tick_e || busy !== e.busy_e) begin
                n_fail++;
                $display("FAIL %s k=%0d clk_out=%b exp %b tick=%b exp %b busy=%b exp %b",
                         e.name, e.k, clk_out, e.clk_e, tick, e.tick_e, busy, e.busy_e);
            end
        end
    endtask

    // Holds reset for two edges with everything idle; caller releases it.
    task automatic hold_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        en     = '0;
        period = '0;
        high   = '0;
        phase  = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{"p4_h2",   4, 2, 0, 12'b011001100110, 12'b010001000100};
`ifdef CLK_GEN_PHASE_EN
        vecs[1] = '{"p5_h1_ph3", 5, 1, 3, 12'b000010000100, 12'b000010000100};
        vecs[5] = '{"p8_h8_ph1", 8, 8, 1, 12'b001111111111, 12'b001000000010};
`else
        vecs[1] = '{"p5_h1_ph3", 5, 1, 3, 12'b010000100001, 12'b010000100001};
        vecs[5] = '{"p8_h8_ph1", 8, 8, 1, 12'b011111111111, 12'b010000000100};
`endif
        vecs[2] = '{"p1_h0",   1, 0, 0, 12'b000000000000, 12'b010101010101};
        vecs[3] = '{"p3_h5",   3, 5, 0, 12'b011111111111, 12'b010010010010};
        vecs[4] = '{"p0_h1",   0, 1, 0, 12'b010101010101, 12'b010101010101};

        clk    = 1'b0;
        rst_n  = 1'b0;
        en     = '0;
        period = '0;
        high   = '0;
        phase  = '0;

        // Reset state
        hold_reset();
        push_seq("reset_state", 1, 16'h0, 16'h0, 16'h0, 4'hF);
        check_cycle();

        // Table: channel 0 only, other channels stay idle and must read 0
        foreach (vecs[v]) begin
            hold_reset();
            set_cfg(0, vecs[v].per, vecs[v].hi, vecs[v].ph);
            rst_n = 1'b1;
            en    = 4'b0001;
            push_seq(vecs[v].name, 12, 16'(vecs[v].clk_e), 16'(vecs[v].tick_e),
                     16'b0000_0111_1111_1111, 4'b0001);
            for (int k = 0; k < 12; k++) check_cycle();
        end

        // Period/high change mid-period takes effect at the boundary
        hold_reset();
        set_cfg(0, 4, 2, 0);
        rst_n = 1'b1;
        en    = 4'b0001;
        push_seq("reconfig", 13, 16'b0_1100_1110_0011, 16'b0_1000_1000_0010,
                 16'b0_1111_1111_1111, 4'b0001);
        for (int k = 0; k < 13; k++) begin
            check_cycle();
            if (k == 2) set_cfg(0, 6, 3, 0);
        end

        // en dropped at cnt=1: period drains, then idle and low
        hold_reset();
        set_cfg(0, 8, 4, 0);
        rst_n = 1'b1;
        en    = 4'b0001;
        push_seq("drain", 13, 16'b0_1111_0000_0000, 16'b0_1000_0000_0000,
                 16'b0_1111_1111_0000, 4'b0001);
        for (int k = 0; k < 13; k++) begin
            check_cycle();
            if (k == 1) en = 4'b0000;
        end

        // Reset while clk_out is high, then common restart on all channels
        hold_reset();
        set_cfg(0, 4, 2, 0);
        rst_n = 1'b1;
        en    = 4'b0001;
        push_seq("pre_reset", 2, 16'b01, 16'b01, 16'b01, 4'b0001);
        check_cycle();
        check_cycle();
        rst_n = 1'b0;
        push_seq("mid_reset", 1, 16'h0, 16'h0, 16'h0, 4'hF);
        check_cycle();
        for (int c = 0; c < 4; c++) set_cfg(c, 4, 2, 0);
        rst_n = 1'b1;
        en    = 4'hF;
        push_seq("aligned", 8, 16'b0110_0110, 16'b0100_0100, 16'b0111_1111, 4'hF);
        for (int k = 0; k < 8; k++) check_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
